// File: rtl/pillbox_pkg.sv
// Shared key codes and dialogue state encoding for the pill-box schedule entry block.
package pillbox_pkg;

  localparam logic [3:0] KEY_SET  = 4'd10;
  localparam logic [3:0] KEY_CLR  = 4'd11;
  localparam logic [3:0] KEY_OK   = 4'd12;
  localparam logic [3:0] KEY_ESC  = 4'd13;
  localparam logic [4:0] KEY_NONE = 5'd16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLOT   = 2'd1,
    DIGITS = 2'd2
  } state_t;

endpackage

// File: rtl/pill_key_edge.sv
// One press event per full release of the keypad; press is combinational from keyvalue.
// Latency 0 (consumer registers it); no backpressure, key-to-key changes without release are dropped.
module pill_key_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] keyvalue,
  input  logic       keyfinish,
  output logic       press,
  output logic [3:0] code
);
  import pillbox_pkg::*;

  logic armed_q, armed_d;

  assign press = armed_q & ~keyvalue[4];
  assign code  = keyvalue[3:0];

  always_comb begin
    armed_d = armed_q;
    if (press) begin
      armed_d = 1'b0;
    end else if (keyfinish && (keyvalue == KEY_NONE)) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b1;
    else        armed_q <= armed_d;
  end

endmodule

// File: rtl/pill_time_entry.sv
// Keypad dialogue SET, slot, HHMM, OK -> validated one-cycle schedule write plus status outputs.
// All outputs registered, one clock after the key appears; no backpressure, idle timeout aborts entry.
module pill_time_entry #(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_W      = 2,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int TO_W        = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        keyvalue,
  input  logic              keyfinish,
  output logic              wr_valid,
  output logic [SLOT_W-1:0] wr_slot,
  output logic [4:0]        wr_hour,
  output logic [5:0]        wr_min,
  output logic              entry_active,
  output logic [15:0]       entry_bcd,
  output logic [2:0]        digit_cnt,
  output logic [3:0]        cur_slot,
  output logic              key_beep,
  output logic              err,
  output logic              timeout
);
  import pillbox_pkg::*;

  localparam logic [3:0]      MAX_SLOT = 4'(NUM_SLOTS);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  logic       press;
  logic [3:0] code;

  pill_key_edge u_key_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .keyvalue  (keyvalue),
    .keyfinish (keyfinish),
    .press     (press),
    .code      (code)
  );

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        slot_q, slot_d;
  logic              wr_valid_q, wr_valid_d;
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic [4:0]        wr_hour_q, wr_hour_d;
  logic [5:0]        wr_min_q, wr_min_d;
  logic              beep_q, beep_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;

  logic [3:0] d0, d1, d2, d3;
  logic [4:0] hour_bin;
  logic [5:0] min_bin;
  logic       time_ok;
  logic       is_digit;

  assign d0 = bcd_q[15:12];
  assign d1 = bcd_q[11:8];
  assign d2 = bcd_q[7:4];
  assign d3 = bcd_q[3:0];

  // x*10 as x*8 + x*2; only the low tens bits matter once time_ok holds
  assign hour_bin = {d0[1:0], 3'b000} + {2'b00, d0[1:0], 1'b0} + {1'b0, d1};
  assign min_bin  = {d2[2:0], 3'b000} + {2'b00, d2[2:0], 1'b0} + {2'b00, d3};
  assign time_ok  = (cnt_q == 3'd4)
                  && ((d0 < 4'd2) || ((d0 == 4'd2) && (d1 < 4'd4)))
                  && (d2 < 4'd6);
  assign is_digit = (code <= 4'd9);

  always_comb begin
    state_d    = state_q;
    to_d       = to_q + 1'b1;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    wr_valid_d = 1'b0;
    wr_slot_d  = wr_slot_q;
    wr_hour_d  = wr_hour_q;
    wr_min_d   = wr_min_q;
    beep_d     = 1'b0;
    err_d      = 1'b0;
    timeout_d  = 1'b0;

    if ((state_q == IDLE) || press) to_d = '0;

    if (press) begin
      unique case (state_q)
        IDLE: begin
          if (code == KEY_SET) begin
            state_d = SLOT;
            beep_d  = 1'b1;
          end
        end
        SLOT: begin
          if (is_digit && (code != 4'd0) && (code <= MAX_SLOT)) begin
            slot_d  = code;
            state_d = DIGITS;
            beep_d  = 1'b1;
          end else if ((code == KEY_CLR) || (code == KEY_ESC)) begin
            state_d = IDLE;
            bcd_d   = '0;
            cnt_d   = '0;
            slot_d  = '0;
            beep_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        DIGITS: begin
          if (is_digit) begin
            if (cnt_q == 3'd4) begin
              err_d = 1'b1;
            end else begin
              case (cnt_q)
                3'd0:    bcd_d[15:12] = code;
                3'd1:    bcd_d[11:8]  = code;
                3'd2:    bcd_d[7:4]   = code;
                default: bcd_d[3:0]   = code;
              endcase
              cnt_d  = cnt_q + 3'd1;
              beep_d = 1'b1;
            end
          end else if (code == KEY_CLR) begin
            beep_d = 1'b1;
            if (cnt_q == 3'd0) begin
              state_d = SLOT;
              slot_d  = '0;
            end else begin
              case (cnt_q)
                3'd1:    bcd_d[15:12] = 4'd0;
                3'd2:    bcd_d[11:8]  = 4'd0;
                3'd3:    bcd_d[7:4]   = 4'd0;
                default: bcd_d[3:0]   = 4'd0;
              endcase
              cnt_d = cnt_q - 3'd1;
            end
          end else if (code == KEY_OK) begin
            if (time_ok) begin
              wr_valid_d = 1'b1;
              wr_slot_d  = SLOT_W'(slot_q - 4'd1);
              wr_hour_d  = hour_bin;
              wr_min_d   = min_bin;
              state_d    = IDLE;
              bcd_d      = '0;
              cnt_d      = '0;
              slot_d     = '0;
              beep_d     = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (code == KEY_ESC) begin
            state_d = IDLE;
            bcd_d   = '0;
            cnt_d   = '0;
            slot_d  = '0;
            beep_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q != IDLE) && (to_q == TO_LAST)) begin
      // a press in this same cycle takes the branch above instead
      state_d   = IDLE;
      bcd_d     = '0;
      cnt_d     = '0;
      slot_d    = '0;
      timeout_d = 1'b1;
      to_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      to_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      slot_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_slot_q  <= '0;
      wr_hour_q  <= '0;
      wr_min_q   <= '0;
      beep_q     <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_q       <= to_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      wr_valid_q <= wr_valid_d;
      wr_slot_q  <= wr_slot_d;
      wr_hour_q  <= wr_hour_d;
      wr_min_q   <= wr_min_d;
      beep_q     <= beep_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign wr_valid     = wr_valid_q;
  assign wr_slot      = wr_slot_q;
  assign wr_hour      = wr_hour_q;
  assign wr_min       = wr_min_q;
  assign entry_active = (state_q != IDLE);
  assign entry_bcd    = bcd_q;
  assign digit_cnt    = cnt_q;
  assign cur_slot     = slot_q;
  assign key_beep     = beep_q;
  assign err          = err_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pill_time_entry.sv
// Directed bench for the pill-box entry dialogue; timeout shortened to 100 cycles.
module tb_pill_time_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  keyvalue;
  logic        keyfinish;
  logic        wr_valid;
  logic [1:0]  wr_slot;
  logic [4:0]  wr_hour;
  logic [5:0]  wr_min;
  logic        entry_active;
  logic [15:0] entry_bcd;
  logic [2:0]  digit_cnt;
  logic [3:0]  cur_slot;
  logic        key_beep;
  logic        err;
  logic        timeout;

  int checks   = 0;
  int failures = 0;
  logic last_beep, last_err, last_wr;
  int beeps;

  always #5 clk = ~clk;

  pill_time_entry #(
    .NUM_SLOTS   (4),
    .SLOT_W      (2),
    .TIMEOUT_CYC (100),
    .TO_W        (29)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .keyvalue     (keyvalue),
    .keyfinish    (keyfinish),
    .wr_valid     (wr_valid),
    .wr_slot      (wr_slot),
    .wr_hour      (wr_hour),
    .wr_min       (wr_min),
    .entry_active (entry_active),
    .entry_bcd    (entry_bcd),
    .digit_cnt    (digit_cnt),
    .cur_slot     (cur_slot),
    .key_beep     (key_beep),
    .err          (err),
    .timeout      (timeout)
  );

  // press for two clocks, sample the response, then release for two clocks
  task automatic key(input logic [4:0] k);
    @(negedge clk);
    keyvalue  = k;
    keyfinish = 1'b0;
    @(negedge clk);
    last_beep = key_beep;
    last_err  = err;
    last_wr   = wr_valid;
    beeps    += int'(key_beep);
    @(negedge clk);
    keyvalue  = 5'd16;
    keyfinish = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    keyvalue  = 5'd16;
    keyfinish = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_valid, wr_slot, wr_hour, wr_min, entry_active, entry_bcd, digit_cnt,
         cur_slot, key_beep, err, timeout} !== 41'd0) begin
      failures++;
      $display("FAIL reset_outs: entry_active=%b bcd=%h cnt=%0d", entry_active, entry_bcd, digit_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_commit();
    beeps = 0;
    key(5'd10);
    checks++;
    if (entry_active !== 1'b1) begin failures++; $display("FAIL set_active: got %b want 1", entry_active); end
    key(5'd2);
    checks++;
    if (cur_slot !== 4'd2) begin failures++; $display("FAIL slot_sel: got %0d want 2", cur_slot); end
    key(5'd0); key(5'd8); key(5'd3); key(5'd0);
    checks++;
    if (entry_bcd !== 16'h0830 || digit_cnt !== 3'd4) begin
      failures++; $display("FAIL digits: got %h/%0d want 0830/4", entry_bcd, digit_cnt);
    end
    key(5'd12);
    checks++;
    if (last_wr !== 1'b1) begin failures++; $display("FAIL commit_strobe: got %b want 1", last_wr); end
    checks++;
    if (wr_slot !== 2'd1 || wr_hour !== 5'd8 || wr_min !== 6'd30) begin
      failures++; $display("FAIL commit_data: got %0d/%0d/%0d want 1/8/30", wr_slot, wr_hour, wr_min);
    end
    checks++;
    if (entry_active !== 1'b0 || entry_bcd !== 16'h0 || digit_cnt !== 3'd0 || cur_slot !== 4'd0) begin
      failures++; $display("FAIL commit_clear: got act=%b bcd=%h cnt=%0d slot=%0d", entry_active, entry_bcd, digit_cnt, cur_slot);
    end
    checks++;
    if (wr_valid !== 1'b0) begin failures++; $display("FAIL strobe_width: got %b want 0", wr_valid); end
    checks++;
    if (beeps !== 7) begin failures++; $display("FAIL beep_count: got %0d want 7", beeps); end
  endtask

  task automatic test_invalid_commit();
    key(5'd10); key(5'd1); key(5'd2); key(5'd4); key(5'd0); key(5'd0);
    key(5'd12);
    checks++;
    if (last_err !== 1'b1 || last_wr !== 1'b0) begin
      failures++; $display("FAIL hour24_err: got err=%b wr=%b want 1/0", last_err, last_wr);
    end
    checks++;
    if (entry_active !== 1'b1 || entry_bcd !== 16'h2400 || digit_cnt !== 3'd4) begin
      failures++; $display("FAIL hour24_keep: got act=%b bcd=%h cnt=%0d", entry_active, entry_bcd, digit_cnt);
    end
    repeat (4) key(5'd11);
    checks++;
    if (entry_bcd !== 16'h0 || digit_cnt !== 3'd0 || cur_slot !== 4'd1 || entry_active !== 1'b1) begin
      failures++; $display("FAIL clr_digits: got bcd=%h cnt=%0d slot=%0d", entry_bcd, digit_cnt, cur_slot);
    end
    key(5'd2); key(5'd3); key(5'd6); key(5'd0);
    key(5'd7);
    checks++;
    if (last_err !== 1'b1 || entry_bcd !== 16'h2360) begin
      failures++; $display("FAIL fifth_digit: got err=%b bcd=%h want 1/2360", last_err, entry_bcd);
    end
    key(5'd12);
    checks++;
    if (last_err !== 1'b1 || last_wr !== 1'b0) begin
      failures++; $display("FAIL min60_err: got err=%b wr=%b want 1/0", last_err, last_wr);
    end
    key(5'd11); key(5'd11); key(5'd5); key(5'd9);
    key(5'd12);
    checks++;
    if (last_wr !== 1'b1 || wr_hour !== 5'd23 || wr_min !== 6'd59 || wr_slot !== 2'd0) begin
      failures++; $display("FAIL commit_2359: got wr=%b %0d:%0d slot=%0d", last_wr, wr_hour, wr_min, wr_slot);
    end
  endtask

  task automatic test_hold();
    key(5'd10); key(5'd3);
    beeps = 0;
    @(negedge clk);
    keyvalue  = 5'd5;
    keyfinish = 1'b0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); beeps += int'(key_beep); end
    keyvalue = 5'd6;
    for (int i = 0; i < 20; i++) begin @(negedge clk); beeps += int'(key_beep); end
    checks++;
    if (beeps !== 1 || digit_cnt !== 3'd1 || entry_bcd !== 16'h5000) begin
      failures++; $display("FAIL hold_once: got beeps=%0d cnt=%0d bcd=%h", beeps, digit_cnt, entry_bcd);
    end
    keyvalue  = 5'd16;
    keyfinish = 1'b1;
    repeat (2) @(negedge clk);
    key(5'd6);
    checks++;
    if (entry_bcd !== 16'h5600 || digit_cnt !== 3'd2) begin
      failures++; $display("FAIL after_release: got bcd=%h cnt=%0d", entry_bcd, digit_cnt);
    end
    key(5'd13);
    checks++;
    if (entry_active !== 1'b0 || entry_bcd !== 16'h0) begin
      failures++; $display("FAIL esc_idle: got act=%b bcd=%h", entry_active, entry_bcd);
    end
  endtask

  task automatic test_slot_errors();
    key(5'd5);
    checks++;
    if (last_beep !== 1'b0 || last_err !== 1'b0 || entry_active !== 1'b0) begin
      failures++; $display("FAIL idle_ignore: got beep=%b err=%b act=%b", last_beep, last_err, entry_active);
    end
    key(5'd10); key(5'd7);
    checks++;
    if (last_err !== 1'b1 || entry_active !== 1'b1 || cur_slot !== 4'd0) begin
      failures++; $display("FAIL slot7: got err=%b act=%b slot=%0d", last_err, entry_active, cur_slot);
    end
    key(5'd0);
    checks++;
    if (last_err !== 1'b1) begin failures++; $display("FAIL slot0: got err=%b want 1", last_err); end
    key(5'd12);
    checks++;
    if (last_err !== 1'b1 || cur_slot !== 4'd0) begin
      failures++; $display("FAIL slot_ok: got err=%b slot=%0d", last_err, cur_slot);
    end
    key(5'd3); key(5'd1); key(5'd11);
    checks++;
    if (digit_cnt !== 3'd0 || cur_slot !== 4'd3) begin
      failures++; $display("FAIL clr_one: got cnt=%0d slot=%0d", digit_cnt, cur_slot);
    end
    key(5'd11);
    checks++;
    if (cur_slot !== 4'd0 || entry_active !== 1'b1) begin
      failures++; $display("FAIL clr_to_slot: got slot=%0d act=%b", cur_slot, entry_active);
    end
    key(5'd11);
    checks++;
    if (entry_active !== 1'b0 || entry_bcd !== 16'h0 || digit_cnt !== 3'd0 || cur_slot !== 4'd0) begin
      failures++; $display("FAIL clr_to_idle: got act=%b bcd=%h cnt=%0d slot=%0d", entry_active, entry_bcd, digit_cnt, cur_slot);
    end
  endtask

  task automatic test_timeout();
    key(5'd10);
    repeat (97) @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || entry_active !== 1'b1) begin
      failures++; $display("FAIL to_early: got to=%b act=%b want 0/1", timeout, entry_active);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1 || entry_active !== 1'b0) begin
      failures++; $display("FAIL to_fire: got to=%b act=%b want 1/0", timeout, entry_active);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL to_pulse: got %b want 0", timeout); end

    key(5'd10);
    repeat (97) @(negedge clk);
    keyvalue  = 5'd2;
    keyfinish = 1'b0;
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || entry_active !== 1'b1 || cur_slot !== 4'd2 || key_beep !== 1'b1) begin
      failures++; $display("FAIL to_press_wins: got to=%b act=%b slot=%0d beep=%b", timeout, entry_active, cur_slot, key_beep);
    end
    keyvalue  = 5'd16;
    keyfinish = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if (entry_active !== 1'b1) begin failures++; $display("FAIL to_restart: got act=%b want 1", entry_active); end
    key(5'd13);
  endtask

  task automatic test_reset_mid();
    key(5'd10); key(5'd1); key(5'd1); key(5'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_valid, wr_slot, wr_hour, wr_min, entry_active, entry_bcd, digit_cnt,
         cur_slot, key_beep, err, timeout} !== 41'd0) begin
      failures++; $display("FAIL async_reset: got act=%b bcd=%h hour=%0d", entry_active, entry_bcd, wr_hour);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    key(5'd12);
    checks++;
    if (last_wr !== 1'b0 || entry_active !== 1'b0 || wr_hour !== 5'd0) begin
      failures++; $display("FAIL ok_after_reset: got wr=%b act=%b hour=%0d", last_wr, entry_active, wr_hour);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_invalid_commit();
    test_hold();
    test_slot_errors();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
